// File: rtl/tour_pkg.sv
// Shared types and constants for the knight's-tour command sequencer.
package tour_pkg;

  typedef enum logic [2:0] {
    IDLE, LOAD, DECODE, LEG1, WAIT1, LEG2, WAIT2
  } tour_state_t;

  // Headings as carried in cmd[11:4]
  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_W = 8'h3F;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_E = 8'hBF;

  // Response bytes towards the UART
  localparam logic [7:0] RESP_DONE = 8'hA5;
  localparam logic [7:0] RESP_POS  = 8'h5A;
  localparam logic [7:0] RESP_ERR  = 8'hEE;

  localparam logic [3:0] MOVE_OPC_DEF = 4'b0010;
  localparam logic [3:0] FF_OPC_DEF   = 4'b0011;

  // Command word layout seen by cmd_proc
  typedef struct packed {
    logic [3:0] opc;
    logic [7:0] hdg;
    logic [3:0] len;
  } tour_cmd_t;

endpackage

// File: rtl/tour_cmd_move_decode.sv
// Splits a one-hot knight move into its 2-square and 1-square leg headings.
module move_decode
  import tour_pkg::*;
(
  input  logic [7:0] move,
  output logic [7:0] hdg1,
  output logic [7:0] hdg2,
  output logic       valid
);

  // Anything that is not exactly one-hot (including zero) is flagged invalid
  always_comb begin
    hdg1  = HDG_N;
    hdg2  = HDG_N;
    valid = 1'b1;
    case (move)
      8'h01: begin hdg1 = HDG_N; hdg2 = HDG_E; end
      8'h02: begin hdg1 = HDG_N; hdg2 = HDG_W; end
      8'h04: begin hdg1 = HDG_W; hdg2 = HDG_N; end
      8'h08: begin hdg1 = HDG_W; hdg2 = HDG_S; end
      8'h10: begin hdg1 = HDG_S; hdg2 = HDG_W; end
      8'h20: begin hdg1 = HDG_S; hdg2 = HDG_E; end
      8'h40: begin hdg1 = HDG_E; hdg2 = HDG_S; end
      8'h80: begin hdg1 = HDG_E; hdg2 = HDG_N; end
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/tour_cmd.sv
// Arbitrates cmd_proc between the UART and an internal knight's-tour
// sequencer; each move becomes a 2-square leg then a 1-square fanfare leg.
module tour_cmd
  import tour_pkg::*;
#(
  parameter int         NUM_MOVES = 24,
  parameter logic [3:0] MOVE_OPC  = MOVE_OPC_DEF,
  parameter logic [3:0] FF_OPC    = FF_OPC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tour_go,
  output logic [4:0]  mv_indx,
  input  logic [7:0]  move,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp_cp,
  output logic        send_resp,
  output logic [7:0]  resp
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

  tour_state_t state;
  tour_cmd_t   cmd_r;
  logic        cmd_rdy_r;
  logic        resp_vld;
  logic [7:0]  resp_r;
  logic [7:0]  hdg2_r;
  logic        pend;   // cmd_proc finished in the same cycle it consumed
  logic [7:0]  hdg1, hdg2;
  logic        mv_ok;
  logic        idle;

  move_decode u_dec (
    .move  (move),
    .hdg1  (hdg1),
    .hdg2  (hdg2),
    .valid (mv_ok)
  );

  assign idle = (state == IDLE);

  // UART owns cmd_proc in IDLE; tour mode drives only registered values.
  // The final/abort response pulse is registered and lands in the first
  // IDLE cycle, so it is OR'd on top of the passthrough.
  assign cmd              = idle ? cmd_UART     : cmd_r;
  assign cmd_rdy          = idle ? cmd_rdy_UART : cmd_rdy_r;
  assign clr_cmd_rdy_UART = idle & clr_cmd_rdy;
  assign send_resp        = resp_vld | (idle & send_resp_cp);
  assign resp             = resp_vld ? resp_r : RESP_DONE;

  // Tour sequencer: fetch, decode, issue two legs, report per move
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mv_indx   <= '0;
      cmd_r     <= '0;
      cmd_rdy_r <= 1'b0;
      resp_vld  <= 1'b0;
      resp_r    <= RESP_DONE;
      hdg2_r    <= HDG_N;
      pend      <= 1'b0;
    end else begin
      resp_vld <= 1'b0;
      case (state)
        IDLE: if (tour_go) begin
          mv_indx <= '0;
          state   <= LOAD;
        end
        LOAD: state <= DECODE;
        DECODE: if (!mv_ok) begin
          resp_vld <= 1'b1;
          resp_r   <= RESP_ERR;
          state    <= IDLE;
        end else begin
          cmd_r     <= '{opc: MOVE_OPC, hdg: hdg1, len: 4'd2};
          hdg2_r    <= hdg2;
          cmd_rdy_r <= 1'b1;
          pend      <= 1'b0;
          state     <= LEG1;
        end
        LEG1, LEG2: if (clr_cmd_rdy) begin
          cmd_rdy_r <= 1'b0;
          pend      <= send_resp_cp;
          state     <= (state == LEG1) ? WAIT1 : WAIT2;
        end
        WAIT1: if (send_resp_cp || pend) begin
          pend      <= 1'b0;
          cmd_r     <= '{opc: FF_OPC, hdg: hdg2_r, len: 4'd1};
          cmd_rdy_r <= 1'b1;
          state     <= LEG2;
        end
        WAIT2: if (send_resp_cp || pend) begin
          pend     <= 1'b0;
          resp_vld <= 1'b1;
          if (mv_indx == LAST_IDX) begin
            resp_r <= RESP_DONE;
            state  <= IDLE;
          end else begin
            resp_r  <= RESP_POS;
            mv_indx <= mv_indx + 5'd1;
            state   <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
